crc32_fifo_drain: RTL

Bit-serial CRC-32 engine that sits on the read side of the peripheral's 8-byte first-word-fall-through input FIFO. It pops bytes from the FIFO and folds each one into a running CRC-32 (IEEE 802.3, reflected) one bit per clock. It exposes the finished checksum to the register interface. This block is the consumer that pairs with the FIFO's `done`/`dout`/`count` read port.

---
 rtl/crc32_pkg.sv | 13 +
 rtl/crc32_bit_step.sv | 15 +
 rtl/crc32_fifo_drain.sv | 120 ++++++++++++
 3 files changed

// File: rtl/crc32_pkg.sv
// crc32_pkg: shared constants and FSM state type for the CRC-32 FIFO drain engine.
package crc32_pkg;

   localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } crc_state_t;

endpackage

// File: rtl/crc32_bit_step.sv
// crc32_bit_step: one reflected CRC-32 bit update, purely combinational.
module crc32_bit_step
   import crc32_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic        bit_i,
   output logic [31:0] crc_o
);

   logic fb;

   assign fb    = crc_i[0] ^ bit_i;
   assign crc_o = (crc_i >> 1) ^ (fb ? CRC32_POLY : 32'h0000_0000);

endmodule

// File: rtl/crc32_fifo_drain.sv
// crc32_fifo_drain: pops bytes from an FWFT FIFO and folds them LSB-first into a CRC-32.
// Optional feature macro: CRC32_BYTE_COUNT_EN adds the CNT_W-bit byte_count port/counter.
//
// state | meaning
// IDLE  | waiting for enable and a non-empty FIFO; clear reinitialises the CRC
// SHIFT | folding one captured byte into the CRC, one bit per cycle (8 cycles)
module crc32_fifo_drain
   import crc32_pkg::*;
`ifdef CRC32_BYTE_COUNT_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic [7:0]       fifo_dout,
   input  logic [3:0]       fifo_count,
   output logic             fifo_done,
   output logic             busy,
`ifdef CRC32_BYTE_COUNT_EN
   output logic [CNT_W-1:0] byte_count,
`endif
   output logic [31:0]      crc_out
);

   crc_state_t  state_q, state_d;
   logic [31:0] crc_q, crc_d, crc_step;
   logic [7:0]  sh_q, sh_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        done_q, done_d;
`ifdef CRC32_BYTE_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   crc32_bit_step u_step (
      .crc_i (crc_q),
      .bit_i (sh_q[0]),
      .crc_o (crc_step)
   );

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      sh_d      = sh_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
`ifdef CRC32_BYTE_COUNT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (clear) begin
               crc_d = CRC32_INIT;
`ifdef CRC32_BYTE_COUNT_EN
               cnt_d = '0;
`endif
            end else if (enable && (fifo_count != 4'd0)) begin
               sh_d      = fifo_dout;
               bit_cnt_d = 3'd0;
               done_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // clear drops the in-flight byte; it has already been popped
            if (clear) begin
               crc_d   = CRC32_INIT;
               state_d = IDLE;
`ifdef CRC32_BYTE_COUNT_EN
               cnt_d   = '0;
`endif
            end else begin
               crc_d     = crc_step;
               sh_d      = sh_q >> 1;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = IDLE;
`ifdef CRC32_BYTE_COUNT_EN
                  cnt_d   = cnt_q + CNT_W'(1);
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         crc_q     <= CRC32_INIT;
         sh_q      <= 8'h00;
         bit_cnt_q <= 3'd0;
         done_q    <= 1'b0;
`ifdef CRC32_BYTE_COUNT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         sh_q      <= sh_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
`ifdef CRC32_BYTE_COUNT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign fifo_done = done_q;
   assign busy      = (state_q == SHIFT);
   assign crc_out   = crc_q ^ CRC32_XOROUT;
`ifdef CRC32_BYTE_COUNT_EN
   assign byte_count = cnt_q;
`endif

endmodule
